// File: rtl/priv_trap_ctrl.sv
// Machine-mode trap/return/WFI sequencer: prioritises exceptions and interrupts, latches the trap CSRs,
// waits for the pipeline to drain and then issues a one-cycle redirect. Optional macro VECTORED_TRAP_EN.
module priv_trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        fault_insn,
  input  logic        mal_insn,
  input  logic        illegal_insn,
  input  logic        breakpoint,
  input  logic        env,
  input  logic        mal_l,
  input  logic        fault_l,
  input  logic        mal_s,
  input  logic        fault_s,
  input  logic        prot_fault_i,
  input  logic        prot_fault_l,
  input  logic        prot_fault_s,
  input  logic        ret,
  input  logic        wfi,
  input  logic        pipe_clear,
  input  logic [31:0] epc,
  input  logic [31:0] badaddr,
  input  logic [31:0] mtvec,
  input  logic        timer_int,
  input  logic        soft_int,
  input  logic        ext_int,
  input  logic        irq_en,
  output logic [31:0] priv_pc,
  output logic        insert_pc,
  output logic        intr,
  output logic [31:0] mepc_q,
  output logic [31:0] mcause_q,
  output logic [31:0] mtval_q,
  output logic        wfi_stall,
  output logic        trap_taken
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_CLEAR = 2'd1,
    REDIRECT   = 2'd2,
    WFI_SLEEP  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] target_r;

  logic        exc_s;
  logic [4:0]  exc_code_s;
  logic        irq_pend_s;
  logic [4:0]  irq_code_s;
  logic        irq_take_s;
  logic        trap_s;
  logic [4:0]  code_s;
  logic [31:0] vec_off_s;
  logic [31:0] target_s;
  logic [31:0] tval_s;

  // Breakpoint and environment calls carry no faulting address.
  function automatic logic code_has_tval(input logic [4:0] code);
    case (code)
      5'd0, 5'd1, 5'd2, 5'd4, 5'd5, 5'd6, 5'd7: code_has_tval = 1'b1;
      default:                                 code_has_tval = 1'b0;
    endcase
  endfunction

  // Exception and interrupt priority encoders plus trap target selection
  always_comb begin
    exc_s      = 1'b1;
    exc_code_s = 5'd0;
    if (fault_insn || prot_fault_i)    exc_code_s = 5'd1;
    else if (mal_insn)                 exc_code_s = 5'd0;
    else if (illegal_insn)             exc_code_s = 5'd2;
    else if (breakpoint)               exc_code_s = 5'd3;
    else if (env)                      exc_code_s = 5'd11;
    else if (mal_l)                    exc_code_s = 5'd4;
    else if (fault_l || prot_fault_l)  exc_code_s = 5'd5;
    else if (mal_s)                    exc_code_s = 5'd6;
    else if (fault_s || prot_fault_s)  exc_code_s = 5'd7;
    else                               exc_s      = 1'b0;

    irq_pend_s = 1'b1;
    irq_code_s = 5'd0;
    if (ext_int)        irq_code_s = 5'd11;
    else if (soft_int)  irq_code_s = 5'd3;
    else if (timer_int) irq_code_s = 5'd7;
    else                irq_pend_s = 1'b0;

    irq_take_s = irq_en && irq_pend_s && !exc_s && !ret;
    trap_s     = exc_s || irq_take_s;
    code_s     = exc_s ? exc_code_s : irq_code_s;

`ifdef VECTORED_TRAP_EN
    if (irq_take_s && (mtvec[1:0] == 2'b01)) begin
      vec_off_s = {25'd0, code_s, 2'b00};
    end else begin
      vec_off_s = 32'd0;
    end
`else
    vec_off_s = 32'd0;
`endif
    // Masking (rather than slicing) keeps the mode bits part of the expression in both builds.
    target_s = (mtvec & 32'hFFFF_FFFC) + vec_off_s;
    tval_s   = (exc_s && code_has_tval(exc_code_s)) ? badaddr : 32'd0;
  end

  // Next-state decode; request inputs only matter while IDLE
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (trap_s)     state_next_s = WAIT_CLEAR;
        else if (ret)   state_next_s = WAIT_CLEAR;
        else if (wfi)   state_next_s = WFI_SLEEP;
        else            state_next_s = IDLE;
      end
      WAIT_CLEAR: begin
        if (pipe_clear) state_next_s = REDIRECT;
        else            state_next_s = WAIT_CLEAR;
      end
      REDIRECT:         state_next_s = IDLE;
      WFI_SLEEP: begin
        if (timer_int || soft_int || ext_int) state_next_s = IDLE;
        else                                  state_next_s = WFI_SLEEP;
      end
      default:          state_next_s = IDLE;
    endcase
  end

  // State register and registered outputs, decoded from the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      trap_taken <= 1'b0;
      intr       <= 1'b0;
      insert_pc  <= 1'b0;
      priv_pc    <= 32'd0;
      wfi_stall  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      trap_taken <= (state_r == IDLE) && trap_s;
      intr       <= (state_next_s == WAIT_CLEAR);
      insert_pc  <= (state_next_s == REDIRECT);
      priv_pc    <= (state_next_s == REDIRECT) ? target_r : 32'd0;
      wfi_stall  <= (state_next_s == WFI_SLEEP);
    end
  end

  // Trap CSRs and the redirect target, captured only when a request is accepted in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      mepc_q   <= 32'd0;
      mcause_q <= 32'd0;
      mtval_q  <= 32'd0;
      target_r <= 32'd0;
    end else if ((state_r == IDLE) && trap_s) begin
      mepc_q   <= epc;
      mcause_q <= {irq_take_s, 26'd0, code_s};
      mtval_q  <= tval_s;
      target_r <= target_s;
    end else if ((state_r == IDLE) && ret) begin
      target_r <= mepc_q;
    end
  end

endmodule

// File: tb/tb_priv_trap_ctrl.sv
// Self-checking bench for priv_trap_ctrl: directed vector table, hand sequences for WFI and reset,
// then randomized transactions checked against a priority-list reference model.
module tb_priv_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fault_insn, mal_insn, illegal_insn, breakpoint, env, mal_l, fault_l, mal_s, fault_s;
  logic        prot_fault_i, prot_fault_l, prot_fault_s;
  logic        ret, wfi, pipe_clear;
  logic [31:0] epc, badaddr, mtvec;
  logic        timer_int, soft_int, ext_int, irq_en;
  logic [31:0] priv_pc, mepc_q, mcause_q, mtval_q;
  logic        insert_pc, intr, wfi_stall, trap_taken;

  always #5 clk = ~clk;

  priv_trap_ctrl dut (
    .clk(clk), .rst(rst),
    .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
    .breakpoint(breakpoint), .env(env), .mal_l(mal_l), .fault_l(fault_l),
    .mal_s(mal_s), .fault_s(fault_s), .prot_fault_i(prot_fault_i),
    .prot_fault_l(prot_fault_l), .prot_fault_s(prot_fault_s),
    .ret(ret), .wfi(wfi), .pipe_clear(pipe_clear),
    .epc(epc), .badaddr(badaddr), .mtvec(mtvec),
    .timer_int(timer_int), .soft_int(soft_int), .ext_int(ext_int), .irq_en(irq_en),
    .priv_pc(priv_pc), .insert_pc(insert_pc), .intr(intr),
    .mepc_q(mepc_q), .mcause_q(mcause_q), .mtval_q(mtval_q),
    .wfi_stall(wfi_stall), .trap_taken(trap_taken)
  );

`ifdef VECTORED_TRAP_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  // Exception flag positions, highest priority first
  localparam int E_FAULT_I = 0, E_PROT_I = 1, E_MAL_I = 2, E_ILL = 3, E_BRK = 4, E_ENV = 5;
  localparam int E_MAL_L = 6, E_FAULT_L = 7, E_PROT_L = 8, E_MAL_S = 9, E_FAULT_S = 10, E_PROT_S = 11;
  localparam int K_NONE = 0, K_TRAP = 1, K_RET = 2;

  // irq bits: [2]=ext_int, [1]=soft_int, [0]=timer_int
  typedef struct {
    logic [11:0] exc;
    logic [2:0]  irq;
    logic        irq_en;
    logic        ret;
    logic [31:0] epc, badaddr, mtvec;
    int          d;
    int          kind;
    logic [31:0] cause, tval, target, mepc;
  } vec_t;

  int exc_code [12] = '{1, 1, 0, 2, 3, 11, 4, 5, 5, 6, 7, 7};
  int irq_bit  [3]  = '{2, 1, 0};
  int irq_code [3]  = '{11, 3, 7};

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_mepc, m_cause, m_tval;
  vec_t        tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    {fault_insn, prot_fault_i, mal_insn, illegal_insn, breakpoint, env} = 6'd0;
    {mal_l, fault_l, prot_fault_l, mal_s, fault_s, prot_fault_s} = 6'd0;
    {ext_int, soft_int, timer_int} = 3'd0;
    ret = 1'b0;
    wfi = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    fault_insn = v.exc[E_FAULT_I]; prot_fault_i = v.exc[E_PROT_I]; mal_insn = v.exc[E_MAL_I];
    illegal_insn = v.exc[E_ILL]; breakpoint = v.exc[E_BRK]; env = v.exc[E_ENV];
    mal_l = v.exc[E_MAL_L]; fault_l = v.exc[E_FAULT_L]; prot_fault_l = v.exc[E_PROT_L];
    mal_s = v.exc[E_MAL_S]; fault_s = v.exc[E_FAULT_S]; prot_fault_s = v.exc[E_PROT_S];
    ext_int = v.irq[2]; soft_int = v.irq[1]; timer_int = v.irq[0];
    irq_en = v.irq_en; ret = v.ret; wfi = 1'b0;
    epc = v.epc; badaddr = v.badaddr; mtvec = v.mtvec;
  endtask

  function automatic vec_t mk(input logic [11:0] exc, input logic [2:0] irq, input logic ien,
                              input logic r, input logic [31:0] pc, input logic [31:0] bad,
                              input logic [31:0] tv, input int d, input int kind,
                              input logic [31:0] cause, input logic [31:0] tval,
                              input logic [31:0] target, input logic [31:0] mepc);
    vec_t v;
    v.exc = exc; v.irq = irq; v.irq_en = ien; v.ret = r;
    v.epc = pc; v.badaddr = bad; v.mtvec = tv; v.d = d; v.kind = kind;
    v.cause = cause; v.tval = tval; v.target = target; v.mepc = mepc;
    return v;
  endfunction

  // Reference model: walk the priority lists, first asserted entry wins
  function automatic vec_t predict(input vec_t v);
    vec_t        r;
    bit          hit = 1'b0;
    bit          is_irq = 1'b0;
    logic [31:0] code = 32'd0;
    r = v;
    r.kind = K_NONE; r.cause = m_cause; r.tval = m_tval; r.mepc = m_mepc; r.target = 32'd0;
    for (int i = 0; i < 12; i++)
      if (!hit && v.exc[i]) begin hit = 1'b1; code = exc_code[i]; end
    if (!hit && !v.ret && v.irq_en)
      for (int j = 0; j < 3; j++)
        if (!hit && v.irq[irq_bit[j]]) begin hit = 1'b1; is_irq = 1'b1; code = irq_code[j]; end
    if (hit) begin
      r.kind   = K_TRAP;
      r.cause  = is_irq ? (32'h8000_0000 + code) : code;
      r.tval   = (!is_irq && code != 3 && code != 11) ? v.badaddr : 32'd0;
      r.mepc   = v.epc;
      r.target = (v.mtvec / 4) * 4;
      if (VEC && is_irq && (v.mtvec % 4 == 1)) r.target = r.target + 4 * code;
    end else if (v.ret) begin
      r.kind   = K_RET;
      r.target = m_mepc;
    end
    return r;
  endfunction

  // One request from IDLE through the drain wait and redirect back to IDLE
  task automatic run_txn(input vec_t v);
    drive(v);
    tick();
    chk("trap_taken", {31'd0, trap_taken}, (v.kind == K_TRAP) ? 32'd1 : 32'd0);
    chk("mcause", mcause_q, v.cause);
    chk("mepc", mepc_q, v.mepc);
    chk("mtval", mtval_q, v.tval);
    if (v.kind == K_NONE) begin
      chk("idle_intr", {31'd0, intr}, 32'd0);
      chk("idle_insert", {31'd0, insert_pc}, 32'd0);
      clear_events();
    end else begin
      // requests raised while busy must be ignored
      clear_events();
      fault_insn = 1'b1; ret = 1'b1; wfi = 1'b1;
      for (int k = 0; k <= v.d; k++) begin
        chk("wait_intr", {31'd0, intr}, 32'd1);
        chk("wait_insert", {31'd0, insert_pc}, 32'd0);
        chk("wait_priv_pc", priv_pc, 32'd0);
        pipe_clear = (k == v.d);
        tick();
      end
      chk("redir_insert", {31'd0, insert_pc}, 32'd1);
      chk("redir_priv_pc", priv_pc, v.target);
      chk("redir_intr", {31'd0, intr}, 32'd0);
      clear_events();
      pipe_clear = 1'b0;
      tick();
      chk("post_insert", {31'd0, insert_pc}, 32'd0);
      chk("post_priv_pc", priv_pc, 32'd0);
      chk("post_mcause", mcause_q, v.cause);
      chk("post_trap_taken", {31'd0, trap_taken}, 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_priv_pc"}, priv_pc, 32'd0);
    chk({tag, "_mepc"}, mepc_q, 32'd0);
    chk({tag, "_mcause"}, mcause_q, 32'd0);
    chk({tag, "_mtval"}, mtval_q, 32'd0);
    chk({tag, "_insert"}, {31'd0, insert_pc}, 32'd0);
    chk({tag, "_intr"}, {31'd0, intr}, 32'd0);
    chk({tag, "_wfi_stall"}, {31'd0, wfi_stall}, 32'd0);
    chk({tag, "_trap_taken"}, {31'd0, trap_taken}, 32'd0);
  endtask

  initial begin
    vec_t v;
    vec_t p;
    tbl[0]  = mk(12'd1 << E_ILL, 3'b000, 1'b0, 1'b0, 32'h100, 32'hDEAD, 32'h8000, 0, K_TRAP,
                 32'd2, 32'hDEAD, 32'h8000, 32'h100);
    tbl[1]  = mk((12'd1 << E_MAL_L) | (12'd1 << E_FAULT_S), 3'b000, 1'b0, 1'b1, 32'h200, 32'h44,
                 32'h9000, 1, K_TRAP, 32'd4, 32'h44, 32'h9000, 32'h200);
    tbl[2]  = mk(12'd0, 3'b101, 1'b1, 1'b0, 32'h300, 32'h55, 32'h8001, 0, K_TRAP,
                 32'h8000_000B, 32'd0, VEC ? 32'h802C : 32'h8000, 32'h300);
    tbl[3]  = mk(12'd0, 3'b000, 1'b0, 1'b1, 32'h333, 32'h99, 32'hA000, 2, K_RET,
                 32'h8000_000B, 32'd0, 32'h300, 32'h300);
    tbl[4]  = mk((12'd1 << E_FAULT_I) | (12'd1 << E_MAL_I) | (12'd1 << E_BRK), 3'b000, 1'b0, 1'b0,
                 32'h400, 32'h66, 32'h1003, 0, K_TRAP, 32'd1, 32'h66, 32'h1000, 32'h400);
    tbl[5]  = mk(12'd1 << E_BRK, 3'b000, 1'b0, 1'b0, 32'h500, 32'h77, 32'h2000, 3, K_TRAP,
                 32'd3, 32'd0, 32'h2000, 32'h500);
    tbl[6]  = mk((12'd1 << E_ENV) | (12'd1 << E_MAL_L), 3'b000, 1'b0, 1'b0, 32'h600, 32'h88,
                 32'h2000, 0, K_TRAP, 32'd11, 32'd0, 32'h2000, 32'h600);
    tbl[7]  = mk(12'd1 << E_PROT_S, 3'b111, 1'b1, 1'b0, 32'h700, 32'hAB, 32'h3001, 1, K_TRAP,
                 32'd7, 32'hAB, 32'h3000, 32'h700);
    tbl[8]  = mk(12'd0, 3'b011, 1'b1, 1'b0, 32'h800, 32'hCD, 32'h4001, 0, K_TRAP,
                 32'h8000_0003, 32'd0, VEC ? 32'h400C : 32'h4000, 32'h800);
    tbl[9]  = mk(12'd0, 3'b100, 1'b0, 1'b0, 32'h900, 32'hEF, 32'h5000, 0, K_NONE,
                 32'h8000_0003, 32'd0, 32'd0, 32'h800);
    tbl[10] = mk(12'd0, 3'b001, 1'b1, 1'b1, 32'hA00, 32'h11, 32'h5000, 0, K_RET,
                 32'h8000_0003, 32'd0, 32'h800, 32'h800);
    tbl[11] = mk(12'd0, 3'b001, 1'b1, 1'b0, 32'hB00, 32'h12, 32'h4002, 2, K_TRAP,
                 32'h8000_0007, 32'd0, 32'h4000, 32'hB00);
    tbl[12] = mk((12'd1 << E_PROT_L) | (12'd1 << E_MAL_S), 3'b000, 1'b0, 1'b0, 32'hC00, 32'h13,
                 32'h6000, 0, K_TRAP, 32'd5, 32'h13, 32'h6000, 32'hC00);
    tbl[13] = mk((12'd1 << E_PROT_I) | (12'd1 << E_ILL), 3'b000, 1'b0, 1'b0, 32'hD00, 32'h14,
                 32'h6000, 0, K_TRAP, 32'd1, 32'h14, 32'h6000, 32'hD00);
    tbl[14] = mk((12'd1 << E_MAL_I) | (12'd1 << E_ILL), 3'b000, 1'b0, 1'b0, 32'hE00, 32'h15,
                 32'h6000, 1, K_TRAP, 32'd0, 32'h15, 32'h6000, 32'hE00);

    clear_events();
    irq_en = 1'b0; pipe_clear = 1'b0; epc = 32'd0; badaddr = 32'd0; mtvec = 32'd0;
    rst = 1'b1;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    m_mepc = 32'd0; m_cause = 32'd0; m_tval = 32'd0;

    for (int i = 0; i < 15; i++) begin
      run_txn(tbl[i]);
      m_mepc = tbl[i].mepc; m_cause = tbl[i].cause; m_tval = tbl[i].tval;
    end

    // WFI with interrupts disabled: sleep, ignore an exception, wake on soft_int without trapping
    clear_events();
    irq_en = 1'b0; wfi = 1'b1;
    tick();
    wfi = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk("wfi_stall", {31'd0, wfi_stall}, 32'd1);
      chk("wfi_intr", {31'd0, intr}, 32'd0);
      chk("wfi_trap_taken", {31'd0, trap_taken}, 32'd0);
      illegal_insn = (k == 2);
      soft_int     = (k == 5);
      tick();
    end
    chk("wake_stall", {31'd0, wfi_stall}, 32'd0);
    chk("wake_intr", {31'd0, intr}, 32'd0);
    chk("wake_trap_taken", {31'd0, trap_taken}, 32'd0);
    chk("wake_mcause", mcause_q, m_cause);
    soft_int = 1'b0;
    tick();
    chk("idle_after_wake_stall", {31'd0, wfi_stall}, 32'd0);
    chk("idle_after_wake_intr", {31'd0, intr}, 32'd0);

    // Reset while waiting for the pipeline to drain
    drive(mk(12'd1 << E_ILL, 3'b000, 1'b0, 1'b0, 32'h1234, 32'h5678, 32'h7000, 0, K_TRAP,
             32'd0, 32'd0, 32'd0, 32'd0));
    tick();
    clear_events();
    pipe_clear = 1'b0;
    chk("rst_seq_cause", mcause_q, 32'd2);
    for (int k = 0; k < 3; k++) begin
      chk("rst_seq_intr", {31'd0, intr}, 32'd1);
      tick();
    end
    rst = 1'b1;
    tick();
    chk_reset_outputs("midtrap_reset");
    rst = 1'b0;
    pipe_clear = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("after_rst_insert", {31'd0, insert_pc}, 32'd0);
      chk("after_rst_intr", {31'd0, intr}, 32'd0);
    end
    pipe_clear = 1'b0;
    m_mepc = 32'd0; m_cause = 32'd0; m_tval = 32'd0;

    for (int n = 0; n < 300; n++) begin
      v = mk(12'd0, 3'b000, 1'b0, 1'b0, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
             K_NONE, 32'd0, 32'd0, 32'd0, 32'd0);
      for (int b = 0; b < 12; b++) v.exc[b] = ($urandom_range(0, 11) == 0);
      for (int b = 0; b < 3; b++)  v.irq[b] = ($urandom_range(0, 2) == 0);
      v.irq_en = $urandom_range(0, 1) == 1;
      v.ret    = $urandom_range(0, 4) == 0;
      p = predict(v);
      run_txn(p);
      if (p.kind == K_TRAP) begin
        m_mepc = p.mepc; m_cause = p.cause; m_tval = p.tval;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
